// File: rtl/dac_slew_limiter.sv
// rtl/dac_slew_limiter.sv - slew-rate limited, clamped DAC code generator
module dac_slew_limiter #(
  parameter int IN_WIDTH  = 24,
  parameter int OUT_WIDTH = 20,
  parameter int DIV_WIDTH = 12
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic [IN_WIDTH-1:0]  data_in,
  input  logic                 data_valid_in,
  input  logic [OUT_WIDTH-1:0] step_in,
  input  logic [DIV_WIDTH-1:0] div_in,
  input  logic [OUT_WIDTH-1:0] min_in,
  input  logic [OUT_WIDTH-1:0] max_in,
  input  logic                 hold_in,
  output logic [OUT_WIDTH-1:0] dac_out,
  output logic                 update_out,
  output logic                 sat_out,
  output logic                 slewing_out
);

  localparam int SHIFT = IN_WIDTH - OUT_WIDTH;

  typedef enum logic [1:0] {IDLE, SLEW, HOLD} state_t;

  state_t                 state;
  logic [OUT_WIDTH-1:0]   target;
  logic [DIV_WIDTH-1:0]   count;

  logic signed [OUT_WIDTH-1:0] scaled;
  logic signed [OUT_WIDTH-1:0] lo;
  logic signed [OUT_WIDTH-1:0] hi;
  logic signed [OUT_WIDTH-1:0] clamped;
  logic                        clipped;
  logic                        unused_low_bits;

  // Dropping the low bits of a two's-complement value is a floor shift.
  assign scaled          = data_in[IN_WIDTH-1:SHIFT];
  assign unused_low_bits = ^data_in[SHIFT-1:0];
  assign lo              = min_in;
  assign hi              = max_in;

  always_comb begin
    clamped = scaled;
    if (lo > hi)          clamped = lo;
    else if (scaled < lo) clamped = lo;
    else if (scaled > hi) clamped = hi;
    clipped = (clamped != scaled);
  end

  logic signed [OUT_WIDTH:0] diff;
  logic [OUT_WIDTH:0]        mag;
  logic [OUT_WIDTH-1:0]      stepped;
  logic [OUT_WIDTH-1:0]      dac_next;
  logic [OUT_WIDTH-1:0]      target_next;
  logic                      tick;
  logic                      move;

  // One extra bit keeps the difference exact across the full code range.
  always_comb begin
    diff = $signed({target[OUT_WIDTH-1], target}) - $signed({dac_out[OUT_WIDTH-1], dac_out});
    mag  = diff[OUT_WIDTH] ? -diff : diff;
    if (mag <= {1'b0, step_in}) stepped = target;
    else if (diff[OUT_WIDTH])   stepped = dac_out - step_in;
    else                        stepped = dac_out + step_in;
  end

  assign tick = (count == '0);

  always_comb begin
    move = 1'b0;
    case (state)
      IDLE:    move = 1'b0;
      SLEW:    move = tick && !hold_in;
      HOLD:    move = tick && !hold_in && slewing_out;
      default: move = 1'b0;
    endcase
  end

  assign dac_next    = move ? stepped : dac_out;
  assign target_next = data_valid_in ? clamped : target;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state       <= IDLE;
      target      <= '0;
      count       <= '0;
      dac_out     <= '0;
      update_out  <= 1'b0;
      sat_out     <= 1'b0;
      slewing_out <= 1'b0;
    end else begin
      count       <= tick ? div_in : count - 1'b1;
      target      <= target_next;
      dac_out     <= dac_next;
      update_out  <= (dac_next != dac_out);
      slewing_out <= (dac_next != target_next);
      if (data_valid_in) sat_out <= clipped;
      if (hold_in)                     state <= HOLD;
      else if (dac_next != target_next) state <= SLEW;
      else                             state <= IDLE;
    end
  end

endmodule

// File: tb/tb_dac_slew_limiter.sv
// tb/tb_dac_slew_limiter.sv - scoreboard bench for dac_slew_limiter
module tb_dac_slew_limiter;
  localparam int IW = 24;
  localparam int OW = 20;
  localparam int DW = 12;

  logic          clk_in = 1'b0;
  logic          rst_in = 1'b1;
  logic [IW-1:0] data_in = '0;
  logic          data_valid_in = 1'b0;
  logic [OW-1:0] step_in = '0;
  logic [DW-1:0] div_in = '0;
  logic [OW-1:0] min_in = 20'h80000;
  logic [OW-1:0] max_in = 20'h7FFFF;
  logic          hold_in = 1'b0;
  logic [OW-1:0] dac_out;
  logic          update_out;
  logic          sat_out;
  logic          slewing_out;

  int vectors = 0;
  int errors  = 0;
  logic [OW-1:0] exp_q[$];

  always #5 clk_in = ~clk_in;

  dac_slew_limiter dut (
    .clk_in(clk_in), .rst_in(rst_in), .data_in(data_in), .data_valid_in(data_valid_in),
    .step_in(step_in), .div_in(div_in), .min_in(min_in), .max_in(max_in), .hold_in(hold_in),
    .dac_out(dac_out), .update_out(update_out), .sat_out(sat_out), .slewing_out(slewing_out)
  );

  // Returns {saturated, clamped code}.
  function automatic logic [OW:0] model(input logic [IW-1:0] d, input logic [OW-1:0] mn, input logic [OW-1:0] mx);
    logic signed [IW-1:0] sh;
    logic signed [OW-1:0] s, l, h, r;
    sh = $signed(d) >>> (IW - OW);
    s  = sh[OW-1:0];
    l  = mn;
    h  = mx;
    if (l > h)      r = l;
    else if (s < l) r = l;
    else if (s > h) r = h;
    else            r = s;
    return {r != s, r};
  endfunction

  task automatic apply_reset();
    rst_in = 1'b0;
    @(negedge clk_in);
    @(negedge clk_in);
    rst_in = 1'b1;
  endtask

  task automatic send(input logic [IW-1:0] d);
    data_in = d;
    data_valid_in = 1'b1;
    @(negedge clk_in);
    data_valid_in = 1'b0;
  endtask

  task automatic test_reset();
    rst_in = 1'b1;
    #1 rst_in = 1'b0;
    #1;
    vectors++; if (dac_out !== '0) begin errors++; $display("FAIL reset_dac got %h want 0", dac_out); end
    vectors++; if ({update_out, sat_out, slewing_out} !== 3'b000) begin
      errors++; $display("FAIL reset_flags got %b want 000", {update_out, sat_out, slewing_out}); end
    @(negedge clk_in);
    rst_in = 1'b1;
  endtask

  task automatic test_single_jump();
    logic [OW:0] m;
    logic [OW-1:0] e;
    int first;
    apply_reset();
    div_in = '0; step_in = 20'hFFFFF; min_in = 20'h80000; max_in = 20'h7FFFF;
    m = model(24'h001230, min_in, max_in);
    exp_q.push_back(m[OW-1:0]);
    send(24'h001230);
    vectors++; if (update_out !== 1'b0 || slewing_out !== 1'b1) begin
      errors++; $display("FAIL jump_target_load got upd=%b slew=%b want upd=0 slew=1", update_out, slewing_out); end
    vectors++; if (sat_out !== m[OW]) begin errors++; $display("FAIL jump_sat got %b want %b", sat_out, m[OW]); end
    first = -1;
    for (int c = 0; c < 20 && exp_q.size() > 0; c++) begin
      @(negedge clk_in);
      if (update_out) begin
        e = exp_q.pop_front(); vectors++;
        if (first < 0) first = c;
        if (dac_out !== e) begin errors++; $display("FAIL jump_dac got %h want %h", dac_out, e); end
      end
    end
    vectors++; if (exp_q.size() != 0) begin errors++; $display("FAIL jump_timeout got %0d pending want 0", exp_q.size()); exp_q.delete(); end
    vectors++; if (first != 0) begin errors++; $display("FAIL jump_latency got %0d want 0", first); end
    vectors++; if (slewing_out !== 1'b0) begin errors++; $display("FAIL jump_settled got %b want 0", slewing_out); end
  endtask

  task automatic test_slew_rate();
    logic [OW-1:0] e;
    int pulses, last;
    apply_reset();
    div_in = 12'd3; step_in = 20'h100;
    for (int k = 1; k <= 16; k++) exp_q.push_back(OW'(k * 'h100));
    send(24'h010000);
    pulses = 0; last = -1;
    for (int c = 0; c < 200 && exp_q.size() > 0; c++) begin
      @(negedge clk_in);
      if (update_out) begin
        e = exp_q.pop_front(); vectors++;
        if (dac_out !== e) begin errors++; $display("FAIL slew_dac got %h want %h", dac_out, e); end
        vectors++;
        if (c != 3 + 4 * pulses) begin errors++; $display("FAIL slew_period got cycle %0d want %0d", c, 3 + 4 * pulses); end
        pulses++; last = c;
      end
    end
    vectors++; if (exp_q.size() != 0) begin errors++; $display("FAIL slew_timeout got %0d pending want 0", exp_q.size()); exp_q.delete(); end
    vectors++; if (pulses != 16) begin errors++; $display("FAIL slew_pulses got %0d want 16 (last %0d)", pulses, last); end
    vectors++; if (slewing_out !== 1'b0) begin errors++; $display("FAIL slew_done got %b want 0", slewing_out); end
    for (int c = 0; c < 8; c++) begin
      @(negedge clk_in);
      vectors++; if (update_out !== 1'b0) begin errors++; $display("FAIL slew_spurious got 1 want 0"); end
    end
  endtask

  task automatic test_clamp();
    logic [IW-1:0] d[4] = '{24'h7FFFFF, 24'h800000, 24'h001000, 24'h000000};
    logic [OW-1:0] mn[4] = '{20'hFFF00, 20'hFFF00, 20'hFFF00, 20'h00050};
    logic [OW-1:0] mx[4] = '{20'h00200, 20'h00200, 20'h00200, 20'h00010};
    logic [OW:0] m;
    logic [OW-1:0] e;
    apply_reset();
    div_in = '0; step_in = 20'hFFFFF;
    for (int i = 0; i < 4; i++) begin
      min_in = mn[i]; max_in = mx[i];
      m = model(d[i], mn[i], mx[i]);
      exp_q.push_back(m[OW-1:0]);
      send(d[i]);
      vectors++; if (sat_out !== m[OW]) begin errors++; $display("FAIL clamp_sat[%0d] got %b want %b", i, sat_out, m[OW]); end
      for (int c = 0; c < 20 && exp_q.size() > 0; c++) begin
        @(negedge clk_in);
        if (update_out) begin
          e = exp_q.pop_front(); vectors++;
          if (dac_out !== e) begin errors++; $display("FAIL clamp_dac[%0d] got %h want %h", i, dac_out, e); end
        end
      end
      vectors++; if (exp_q.size() != 0) begin errors++; $display("FAIL clamp_timeout[%0d] pending %0d want 0", i, exp_q.size()); exp_q.delete(); end
    end
    min_in = 20'h80000; max_in = 20'h7FFFF;
  endtask

  task automatic test_hold_and_back_to_back();
    logic [OW-1:0] held, v, e;
    apply_reset();
    div_in = '0; step_in = 20'h10;
    send(24'h010000);
    repeat (3) @(negedge clk_in);
    hold_in = 1'b1;
    held = dac_out;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk_in);
      vectors++;
      if (update_out !== 1'b0 || dac_out !== held || slewing_out !== 1'b1) begin
        errors++; $display("FAIL hold_cycle%0d got upd=%b dac=%h slew=%b want upd=0 dac=%h slew=1", c, update_out, dac_out, slewing_out, held);
      end
    end
    hold_in = 1'b0;
    @(negedge clk_in);
    vectors++; if (update_out !== 1'b1 || dac_out !== held + 20'h10) begin
      errors++; $display("FAIL hold_resume got upd=%b dac=%h want upd=1 dac=%h", update_out, dac_out, held + 20'h10); end
    step_in = '0;
    v = dac_out;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk_in);
      vectors++; if (update_out !== 1'b0 || dac_out !== v || slewing_out !== 1'b1) begin
        errors++; $display("FAIL step0_cycle%0d got upd=%b dac=%h slew=%b want upd=0 dac=%h slew=1", c, update_out, dac_out, slewing_out, v); end
    end
    // Same-cycle tick still heads for the old target, then turns around.
    step_in = 20'h10;
    exp_q.push_back(v + 20'h10);
    exp_q.push_back(v);
    send(24'h000000);
    vectors++; if (update_out !== 1'b1 || dac_out !== exp_q[0]) begin
      errors++; $display("FAIL b2b_old_target got upd=%b dac=%h want upd=1 dac=%h", update_out, dac_out, exp_q[0]); end
    void'(exp_q.pop_front());
    for (int c = 0; c < 10 && exp_q.size() > 0; c++) begin
      @(negedge clk_in);
      if (update_out) begin
        e = exp_q.pop_front(); vectors++;
        if (dac_out !== e) begin errors++; $display("FAIL b2b_dac got %h want %h", dac_out, e); end
      end
    end
    vectors++; if (exp_q.size() != 0) begin errors++; $display("FAIL b2b_timeout pending %0d want 0", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_full_swing();
    logic [IW-1:0] d[2] = '{24'h800000, 24'h7FFFF0};
    logic [OW:0] m;
    logic [OW-1:0] e;
    int pulses;
    apply_reset();
    div_in = '0; step_in = 20'hFFFFF;
    for (int i = 0; i < 2; i++) begin
      m = model(d[i], min_in, max_in);
      exp_q.push_back(m[OW-1:0]);
      send(d[i]);
      pulses = 0;
      for (int c = 0; c < 6; c++) begin
        @(negedge clk_in);
        if (update_out) begin
          pulses++;
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front(); vectors++;
            if (dac_out !== e) begin errors++; $display("FAIL swing_dac[%0d] got %h want %h", i, dac_out, e); end
          end
        end
      end
      vectors++; if (pulses != 1) begin errors++; $display("FAIL swing_pulses[%0d] got %0d want 1", i, pulses); exp_q.delete(); end
      vectors++; if (sat_out !== 1'b0 || slewing_out !== 1'b0) begin
        errors++; $display("FAIL swing_flags[%0d] got sat=%b slew=%b want 0 0", i, sat_out, slewing_out); end
    end
  endtask

  task automatic test_async_reset();
    logic [OW-1:0] e;
    apply_reset();
    div_in = '0; step_in = 20'h10;
    send(24'h010000);
    repeat (3) @(negedge clk_in);
    #2 rst_in = 1'b0;
    #1;
    vectors++; if (dac_out !== '0 || {update_out, sat_out, slewing_out} !== 3'b000) begin
      errors++; $display("FAIL async_reset got dac=%h flags=%b want 0 000", dac_out, {update_out, sat_out, slewing_out}); end
    @(negedge clk_in);
    rst_in = 1'b1;
    @(negedge clk_in);
    vectors++; if (update_out !== 1'b0 || dac_out !== '0) begin
      errors++; $display("FAIL async_release got upd=%b dac=%h want 0 0", update_out, dac_out); end
    step_in = 20'hFFFFF;
    exp_q.push_back(20'h00123);
    send(24'h001230);
    for (int c = 0; c < 20 && exp_q.size() > 0; c++) begin
      @(negedge clk_in);
      if (update_out) begin
        e = exp_q.pop_front(); vectors++;
        if (dac_out !== e) begin errors++; $display("FAIL async_after got %h want %h", dac_out, e); end
      end
    end
    vectors++; if (exp_q.size() != 0) begin errors++; $display("FAIL async_timeout pending %0d want 0", exp_q.size()); exp_q.delete(); end
  endtask

  initial begin
    test_reset();
    test_single_jump();
    test_slew_rate();
    test_clamp();
    test_hold_and_back_to_back();
    test_full_swing();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/dac_slew_limiter.md
DAC_SLEW_LIMITER -- requirements
Module: dac_slew_limiter

Interface
REQ-001 The block SHALL have parameter IN_WIDTH, default 24, the width of the servo output sample.
REQ-002 The block SHALL have parameter OUT_WIDTH, default 20, the DAC code width presented to the DAC driver.
REQ-003 The block SHALL have parameter DIV_WIDTH, default 12, the update divider width.
REQ-004 The block SHALL have the following ports, in this order:
- clk_in  input  1  system clock; one clock domain, all logic on rising edge.
- rst_in  input  1  asynchronous, active-low reset.
- data_in  input  IN_WIDTH  signed servo sample.
- data_valid_in  input  1  qualifies data_in for one cycle.
- step_in  input  OUT_WIDTH  unsigned maximum code change per update.
- div_in  input  DIV_WIDTH  update period minus one, in clk_in cycles.
- min_in  input  OUT_WIDTH  signed lower clamp.
- max_in  input  OUT_WIDTH  signed upper clamp.
- hold_in  input  1  freezes dac_out while high.
- dac_out  output  OUT_WIDTH  signed registered code, feeding the DAC driver's DAC_in.
- update_out  output  1  one-cycle pulse when dac_out changes.
- sat_out  output  1  last accepted sample was clamped.
- slewing_out  output  1  dac_out differs from target.

Function
REQ-005 The block SHALL capture data_in on any cycle with data_valid_in high, regardless of hold_in or state.
REQ-006 Scaling SHALL be an arithmetic right shift by IN_WIDTH-OUT_WIDTH (floor, toward minus infinity); no rounding.
REQ-007 The scaled value SHALL be clamped to [min_in, max_in] using signed compare; if min_in > max_in the result SHALL be min_in.
REQ-008 The clamped value SHALL load the target register one cycle after data_valid_in.
REQ-009 sat_out SHALL update on that same cycle: 1 if clamping altered the value, else 0; it SHALL hold until the next valid sample.
REQ-010 A down-counter SHALL reload with div_in when it reaches 0 and generate a tick on that cycle; div_in=0 SHALL tick every cycle; div_in changes SHALL take effect at the next reload.
REQ-011 The state machine SHALL have three states:
- IDLE: dac_out==target.
- SLEW: dac_out!=target and hold_in low.
- HOLD: hold_in high.
REQ-012 On a tick in SLEW, with diff = target - dac_out computed at OUT_WIDTH+1 bits, dac_out SHALL:
- become target if |diff| <= step_in;
- otherwise move by +step_in or -step_in per the sign of diff.
REQ-013 The dac_out result SHALL never wrap: the full-scale swing from -2^19 to 2^19-1 with step_in = 2^20-1 SHALL land exactly on target.
REQ-014 step_in=0 SHALL leave dac_out unchanged; the state SHALL remain SLEW.
REQ-015 In HOLD, dac_out SHALL NOT change and ticks SHALL be ignored; the counter SHALL keep running.
REQ-016 On deassertion of hold_in, the block SHALL go to IDLE or SLEW per the compare.
REQ-017 update_out SHALL pulse high for exactly the cycle in which the new dac_out value first appears; it SHALL never pulse without a change.
REQ-018 slewing_out SHALL be high exactly when dac_out != target, including while in HOLD.
REQ-019 If a new sample arrives during SLEW, the target SHALL be replaced and the slew SHALL continue toward the new target from the current dac_out.
REQ-020 If a tick and data_valid_in occur in the same cycle, the tick SHALL use the old target.

Reset
REQ-021 rst_in low SHALL asynchronously set:
- dac_out, target, counter: 0
- update_out, sat_out, slewing_out: 0
- state: IDLE
REQ-022 The first tick after release SHALL occur when the counter, which reloads div_in at that first tick, first reaches 0, i.e. on the first clock after release.
REQ-023 Reset asserted mid-slew SHALL abandon the slew; dac_out SHALL be 0 with no update_out pulse.

Verification
REQ-024 Scenario 1: div_in=0, step_in=0xFFFFF, data_in=0x001230 valid -> target 0x00123 next cycle; dac_out=0x00123 with update_out one cycle later; sat_out=0.
REQ-025 Scenario 2: step_in=0x100, div_in=3, data_in=0x010000 from dac_out 0 -> dac_out goes 0x100, 0x200, ... 0x1000, one step every 4 cycles, 16 update_out pulses, then slewing_out=0.
REQ-026 Scenario 3: min_in=-0x100, max_in=0x200, data_in=0x7FFFFF -> target 0x200, sat_out=1; then data_in=-0x800000 -> target -0x100, sat_out=1.
REQ-027 Scenario 4: hold_in high mid-slew for 20 cycles -> dac_out constant, no update_out, slewing_out=1; after release, slewing resumes at the next tick.
REQ-028 Scenario 5: step_in=0xFFFFF from dac_out=-0x80000 to target 0x7FFFF -> single update to 0x7FFFF, no wrap.
REQ-029 Scenario 6: rst_in pulsed low asynchronously mid-slew, between clock edges -> all outputs 0 immediately; normal operation after release.
